// File: rtl/trace_capture_if.sv
// Read-side handshake bundle of trace_capture: the unit drives valid/data, the consumer drives ready.
interface trace_capture_if #(
  parameter int EW = 86
);
  logic          rd_valid;
  logic          rd_ready;
  logic [EW-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/trace_capture.sv
// trace_capture: per-cycle PC / register-write trace into a DEPTH-entry FIFO with a valid/ready drain port.
// Build macro TRACE_WRITE_ONLY_EN: push only RUN cycles that write the register file (stamps stay absolute).
module trace_capture #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int RW           = 5,
  parameter int CW           = 16,
  parameter int DEPTH        = 16,
  parameter int MAX_CYCLES   = 30,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic                   halt_i,
  input  logic [AW-1:0]          pc_i,
  input  logic                   wr_en_i,
  input  logic [RW-1:0]          wr_addr_i,
  input  logic [DW-1:0]          wr_data_i,
  trace_capture_if.master        rd,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic [CW-1:0]          drop_cnt_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = CW + AW + 1 + RW + DW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [EW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_level;
  logic           r_ovf;
  logic [CW-1:0]  r_drop_cnt;

  logic           w_run;
  logic           w_clear;
  logic           w_full;
  logic           w_empty;
  logic           w_push_req;
  logic           w_push;
  logic           w_pop;
  logic           w_drop;
  logic           w_last;
  logic           w_fill_stop;
  logic [EW-1:0]  w_entry;

  assign w_run   = (r_state == S_RUN);
  assign w_clear = (r_state == S_DONE) && clear_i;
  assign w_full  = (r_level == (PW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_last  = (r_cnt == CW'(MAX_CYCLES - 1));
  assign w_entry = {r_cnt, pc_i, wr_en_i, wr_addr_i, wr_data_i};

`ifdef TRACE_WRITE_ONLY_EN
  assign w_push_req = w_run && wr_en_i;
`else
  assign w_push_req = w_run;
`endif

  // A pop in the clearing cycle is discarded; a full FIFO still accepts a push when it pops that edge.
  assign w_pop       = !w_empty && rd.rd_ready && !w_clear;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_fill_stop = STOP_ON_FULL && w_push && !w_pop && (r_level == (PW+1)'(DEPTH - 1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_RUN;
               else         w_state_nxt = S_IDLE;
      S_RUN:   if (w_last || halt_i || w_fill_stop) w_state_nxt = S_DONE;
               else                                 w_state_nxt = S_RUN;
      S_DONE:  if (clear_i) w_state_nxt = S_IDLE;
               else         w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Cycle stamp counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                               r_cnt <= '0;
    else if ((r_state == S_IDLE) && start_i) r_cnt <= '0;
    else if (w_run)                          r_cnt <= r_cnt + CW'(1);
    else if (w_clear)                        r_cnt <= '0;
    else                                     r_cnt <= r_cnt;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (PW+1)'(1);
      else if (w_pop && !w_push) r_level <= r_level - (PW+1)'(1);
      else                       r_level <= r_level;
    end
  end

  // FIFO storage; stale contents are masked by the empty check on the read side
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // Drop tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_clear) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CW'(1);
    end
  end

  assign rd.rd_valid = !w_empty;
  assign rd.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign busy_o      = (r_state == S_RUN);
  assign done_o      = (r_state == S_DONE);
  assign overflow_o  = r_ovf;
  assign drop_cnt_o  = r_drop_cnt;
  assign level_o     = r_level;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: one DEPTH=8 dropping instance and one DEPTH=8 stop-on-full instance.
module tb_trace_capture;
  localparam int AW = 32, DW = 32, RW = 5, CW = 16, DEPTH = 8, MAXC = 30;
  localparam int EW = CW + AW + 1 + RW + DW;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, clear = 1'b0, halt = 1'b0;
  logic sof_start = 1'b0, sof_clear = 1'b0, sof_halt = 1'b0;
  logic [AW-1:0] pc = '0;
  logic wr_en = 1'b1;
  logic [RW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic busy, done, ovf, sof_busy, sof_done, sof_ovf;
  logic [CW-1:0] drop, sof_drop;
  logic [3:0] level, sof_level;

  int tests = 0, fails = 0;
  logic [EW-1:0] got_q[$];
  logic          got_done_q[$];

  trace_capture_if #(.EW(EW)) dut_if();
  trace_capture_if #(.EW(EW)) sof_if();

  trace_capture #(.AW(AW), .DW(DW), .RW(RW), .CW(CW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC),
                  .STOP_ON_FULL(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .halt_i(halt),
    .pc_i(pc), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd(dut_if.master),
    .busy_o(busy), .done_o(done), .overflow_o(ovf), .drop_cnt_o(drop), .level_o(level));

  trace_capture #(.AW(AW), .DW(DW), .RW(RW), .CW(CW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC),
                  .STOP_ON_FULL(1'b1)) u_sof (
    .clk_i(clk), .rst_i(rst), .start_i(sof_start), .clear_i(sof_clear), .halt_i(sof_halt),
    .pc_i(pc), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd(sof_if.master),
    .busy_o(sof_busy), .done_o(sof_done), .overflow_o(sof_ovf), .drop_cnt_o(sof_drop),
    .level_o(sof_level));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] exp_entry(input int s, input logic en);
    logic [CW-1:0] st;
    logic [RW-1:0] ad;
    st = s[CW-1:0];
    ad = s[RW-1:0];
    return {st, 32'(4 * s), en, ad, 32'hA500_0000 ^ 32'(s)};
  endfunction

  task automatic drive(input int k, input bit sel);
    pc      = 32'(4 * k);
    wr_addr = k[RW-1:0];
    wr_data = 32'hA500_0000 ^ 32'(k);
    wr_en   = sel ? ((k == 3) || (k == 9)) : 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Start a run on u_dut with rd_ready=1, collect every entry until done and drained.
  task automatic run_collect(input int halt_at, input bit sel);
    int k;
    bit fin;
    got_q.delete();
    got_done_q.delete();
    dut_if.rd_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    fin = 1'b0;
    drive(k, sel);
    for (int c = 0; c < 100 && !fin; c++) begin
      halt = (k == halt_at);
      tick();
      halt = 1'b0;
      if (dut_if.rd_valid) begin
        got_q.push_back(dut_if.rd_data);
        got_done_q.push_back(done);
      end else if (done) begin
        fin = 1'b1;
      end
      k++;
      drive(k, sel);
    end
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL collect_timeout: done=%0b required 1", done);
    end
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if ({busy, done, ovf, drop, level, dut_if.rd_valid, dut_if.rd_data} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%0b done=%0b ovf=%0b drop=%0d level=%0d valid=%0b required all 0",
               busy, done, ovf, drop, level, dut_if.rd_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int bad = 0;
    run_collect(-1, 1'b0);
    tests++;
    if (got_q.size() != 30) begin
      fails++;
      $display("FAIL basic_count: got %0d entries required 30", got_q.size());
    end else begin
      for (int i = 0; i < 30; i++) if (got_q[i] !== exp_entry(i, 1'b1)) bad++;
      if (bad != 0) begin
        fails++;
        $display("FAIL basic_entries: %0d wrong entries required 0 (first %h vs %h)",
                 bad, got_q[0], exp_entry(0, 1'b1));
      end
      tests++;
      if (got_done_q[29] !== 1'b1 || got_done_q[28] !== 1'b0) begin
        fails++;
        $display("FAIL basic_done_timing: done@28=%0b done@29=%0b required 0 1",
                 got_done_q[28], got_done_q[29]);
      end
    end
    tests++;
    if (ovf !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_flags: ovf=%0b done=%0b busy=%0b required 0 1 0", ovf, done, busy);
    end
    do_clear();
  endtask

  task automatic test_halt();
    int bad = 0;
    run_collect(5, 1'b0);
    tests++;
    if (got_q.size() != 6) begin
      fails++;
      $display("FAIL halt_count: got %0d entries required 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) if (got_q[i] !== exp_entry(i, 1'b1)) bad++;
      if (bad != 0 || got_done_q[5] !== 1'b1) begin
        fails++;
        $display("FAIL halt_entries: %0d wrong, done@5=%0b required 0 wrong, done 1", bad, got_done_q[5]);
      end
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL halt_state: done=%0b busy=%0b required 1 0", done, busy);
    end
    do_clear();
  endtask

  task automatic test_overflow();
    int k = 0;
    dut_if.rd_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(k, 1'b0);
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      k++;
      drive(k, 1'b0);
    end
    tests++;
    if (level !== 4'd8 || drop !== 16'd22 || ovf !== 1'b1 || done !== 1'b1) begin
      fails++;
      $display("FAIL overflow_flags: level=%0d drop=%0d ovf=%0b done=%0b required 8 22 1 1",
               level, drop, ovf, done);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (dut_if.rd_valid !== 1'b1 || dut_if.rd_data !== exp_entry(i, 1'b1)) begin
        fails++;
        $display("FAIL overflow_drain%0d: got %h required %h", i, dut_if.rd_data, exp_entry(i, 1'b1));
      end
      dut_if.rd_ready = 1'b1;
      tick();
      dut_if.rd_ready = 1'b0;
    end
    tests++;
    if (level !== 4'd4) begin
      fails++;
      $display("FAIL overflow_level_after_drain: level=%0d required 4", level);
    end
    dut_if.rd_ready = 1'b1;
    do_clear();
    dut_if.rd_ready = 1'b0;
    tests++;
    if ({level, ovf, drop, done, busy, dut_if.rd_valid, dut_if.rd_data} !== '0) begin
      fails++;
      $display("FAIL clear_flags: level=%0d ovf=%0b drop=%0d done=%0b valid=%0b required all 0",
               level, ovf, drop, done, dut_if.rd_valid);
    end
  endtask

  task automatic test_full_push_pop();
    int k = 0;
    dut_if.rd_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(k, 1'b0);
    for (int i = 0; i < 8; i++) begin
      clear = (k == 6);
      tick();
      clear = 1'b0;
      k++;
      drive(k, 1'b0);
    end
    tests++;
    if (level !== 4'd8 || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_fill: level=%0d busy=%0b required 8 1", level, busy);
    end
    dut_if.rd_ready = 1'b1;
    tick();
    k++;
    drive(k, 1'b0);
    tests++;
    if (level !== 4'd8 || drop !== 16'd0 || dut_if.rd_data !== exp_entry(1, 1'b1)) begin
      fails++;
      $display("FAIL full_push_pop: level=%0d drop=%0d head=%h required 8 0 %h",
               level, drop, dut_if.rd_data, exp_entry(1, 1'b1));
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    dut_if.rd_ready = 1'b0;
    tests++;
    if (level !== 4'd8 || done !== 1'b1 || ovf !== 1'b0 || dut_if.rd_data !== exp_entry(2, 1'b1)) begin
      fails++;
      $display("FAIL full_halt: level=%0d done=%0b ovf=%0b head=%h required 8 1 0 %h",
               level, done, ovf, dut_if.rd_data, exp_entry(2, 1'b1));
    end
    for (int i = 2; i < 10; i++) begin
      tests++;
      if (dut_if.rd_data !== exp_entry(i, 1'b1)) begin
        fails++;
        $display("FAIL full_order%0d: got %h required %h", i, dut_if.rd_data, exp_entry(i, 1'b1));
      end
      dut_if.rd_ready = 1'b1;
      tick();
    end
    tick();
    tests++;
    if (dut_if.rd_valid !== 1'b0 || level !== 4'd0) begin
      fails++;
      $display("FAIL empty_ready: valid=%0b level=%0d required 0 0", dut_if.rd_valid, level);
    end
    dut_if.rd_ready = 1'b0;
    do_clear();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_to_idle: done=%0b busy=%0b required 0 0", done, busy);
    end
  endtask

  task automatic test_stop_on_full();
    int k = 0;
    int stop_at = -1;
    sof_if.rd_ready = 1'b0;
    sof_start = 1'b1;
    tick();
    sof_start = 1'b0;
    drive(k, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sof_done) begin
        stop_at = i;
        break;
      end
      k++;
      drive(k, 1'b0);
    end
    tests++;
    if (stop_at != 7 || sof_level !== 4'd8 || sof_drop !== 16'd0 || sof_ovf !== 1'b0) begin
      fails++;
      $display("FAIL stop_on_full: stop_stamp=%0d level=%0d drop=%0d ovf=%0b required 7 8 0 0",
               stop_at, sof_level, sof_drop, sof_ovf);
    end
    tests++;
    if (sof_if.rd_data !== exp_entry(0, 1'b1)) begin
      fails++;
      $display("FAIL stop_on_full_head: got %h required %h", sof_if.rd_data, exp_entry(0, 1'b1));
    end
    sof_clear = 1'b1;
    tick();
    sof_clear = 1'b0;
  endtask

  task automatic test_async_reset();
    int k = 0;
    dut_if.rd_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(k, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick();
      k++;
      drive(k, 1'b0);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, ovf, drop, level, dut_if.rd_valid, dut_if.rd_data} !== '0) begin
      fails++;
      $display("FAIL async_reset: busy=%0b done=%0b ovf=%0b drop=%0d level=%0d valid=%0b required all 0",
               busy, done, ovf, drop, level, dut_if.rd_valid);
    end
    #1 rst = 1'b0;
    run_collect(2, 1'b0);
    tests++;
    if (got_q.size() != 3 || got_q[0] !== exp_entry(0, 1'b1)) begin
      fails++;
      $display("FAIL restart_stamp0: count=%0d required 3, first entry must be stamp 0", got_q.size());
    end
    do_clear();
  endtask

  task automatic test_write_only();
    run_collect(-1, 1'b1);
    tests++;
`ifdef TRACE_WRITE_ONLY_EN
    if (got_q.size() != 2 || got_q[0] !== exp_entry(3, 1'b1) || got_q[1] !== exp_entry(9, 1'b1)) begin
      fails++;
      $display("FAIL write_only: count=%0d required 2 entries with stamps 3 and 9", got_q.size());
    end
`else
    if (got_q.size() != 30 || got_q[3] !== exp_entry(3, 1'b1) || got_q[4] !== exp_entry(4, 1'b0)) begin
      fails++;
      $display("FAIL write_only_disabled: count=%0d required 30 with wr_en only on stamps 3,9",
               got_q.size());
    end
`endif
    do_clear();
    wr_en = 1'b1;
  endtask

  initial begin
    dut_if.rd_ready = 1'b0;
    sof_if.rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_halt();
    test_overflow();
    test_full_push_pop();
    test_stop_on_full();
    test_async_reset();
    test_write_only();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
